// File: rtl/cascade_pkg.sv
// Shared types and width helpers for the cascade classifier stage logic.
// No ports. Provides:
//   acc_width()  accumulator width needed to sum max_wc leaves of w_leaf bits
//   leaf_t, acc_t, thr_t, stg_t   default-configuration scalar types
//   result_t     {ch, result, stage} decision record handed to the scheduler
package cascade_pkg;

    localparam int CASCADE_W_LEAF            = 13;
    localparam int CASCADE_MAX_WEAKCOUNT     = 211;
    localparam int CASCADE_STAGE_NUM         = 25;
    localparam int CASCADE_W_STAGE_THRESHOLD = 11;
    localparam int CASCADE_N_CH              = 4;

    // Growth of log2(count) bits guarantees that no sum of leaves can overflow.
    function automatic int acc_width(input int w_leaf, input int max_wc);
        return w_leaf + $clog2(max_wc);
    endfunction

    localparam int CASCADE_W_CH  = (CASCADE_N_CH > 1) ? $clog2(CASCADE_N_CH) : 1;
    localparam int CASCADE_W_STG = $clog2(CASCADE_STAGE_NUM);
    localparam int CASCADE_W_ACC = acc_width(CASCADE_W_LEAF, CASCADE_MAX_WEAKCOUNT);

    typedef logic signed [CASCADE_W_LEAF-1:0]            leaf_t;
    typedef logic signed [CASCADE_W_ACC-1:0]             acc_t;
    typedef logic signed [CASCADE_W_STAGE_THRESHOLD-1:0] thr_t;
    typedef logic        [CASCADE_W_STG-1:0]             stg_t;

    typedef struct packed {
        logic [CASCADE_W_CH-1:0] ch;
        logic                    result;
        stg_t                    stage;
    } result_t;

endpackage

// File: rtl/stage_threshold_rf.sv
// Stage threshold register file: STAGE_NUM entries of W_STAGE_THRESHOLD bits.
// Contents are deliberately not reset; software loads them before use.
// Ports:
//   clk        clock
//   wr_en_i    write strobe (ignored when wr_addr_i is out of range)
//   wr_addr_i  write index
//   wr_data_i  write data
//   rd_addr_i  combinational read index
//   rd_data_o  combinational read data (reflects writes from the next cycle on)
module stage_threshold_rf #(
    parameter int STAGE_NUM         = 25,
    parameter int W_STAGE_THRESHOLD = 11,
    parameter int W_STG             = $clog2(STAGE_NUM)
) (
    input  logic                         clk,
    input  logic                         wr_en_i,
    input  logic [W_STG-1:0]             wr_addr_i,
    input  logic [W_STAGE_THRESHOLD-1:0] wr_data_i,
    input  logic [W_STG-1:0]             rd_addr_i,
    output logic [W_STAGE_THRESHOLD-1:0] rd_data_o
);

    logic [W_STAGE_THRESHOLD-1:0] mem_q [STAGE_NUM];
    logic                         addr_ok;

    // Compare in one extra bit so the check stays meaningful when STAGE_NUM is 2**W_STG.
    assign addr_ok = {1'b0, wr_addr_i} < (W_STG+1)'(STAGE_NUM);

    always_ff @(posedge clk) begin
        if (wr_en_i && addr_ok) mem_q[wr_addr_i] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/stage_accum_mc.sv
// Multi-channel cascade stage accumulator.
// Sums signed leaf values per interleaved window channel; on the last leaf of a
// stage compares the sum with that channel's current stage threshold and either
// advances the channel to its next stage or emits a reject/accept decision
// through a one-entry output register.
// Optional feature: define STAGE_ACCUM_MC_DEPTH_OUT_EN to add result_stage.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   din_valid/din_ready              leaf beat handshake
//   din_data, din_ch, din_eot        signed leaf, channel, last-leaf-of-stage flag
//   cfg_we, cfg_addr, cfg_data       threshold write port
//   result_valid/result_ready        decision handshake
//   result, result_ch                1 = passed all stages, channel of decision
//   result_stage (optional)          stage index at which the decision was taken
module stage_accum_mc
    import cascade_pkg::*;
#(
    parameter int W_LEAF            = 13,
    parameter int MAX_WEAKCOUNT     = 211,
    parameter int STAGE_NUM         = 25,
    parameter int W_STAGE_THRESHOLD = 11,
    parameter int N_CH              = 4,
    localparam int W_CH  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int W_STG = $clog2(STAGE_NUM),
    localparam int W_ACC = acc_width(W_LEAF, MAX_WEAKCOUNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic [W_LEAF-1:0]            din_data,
    input  logic [W_CH-1:0]              din_ch,
    input  logic                         din_eot,
    input  logic                         cfg_we,
    input  logic [W_STG-1:0]             cfg_addr,
    input  logic [W_STAGE_THRESHOLD-1:0] cfg_data,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic                         result,
`ifdef STAGE_ACCUM_MC_DEPTH_OUT_EN
    output logic [W_STG-1:0]             result_stage,
`endif
    output logic [W_CH-1:0]              result_ch
);

    logic [N_CH-1:0][W_ACC-1:0] acc_q, acc_d;
    logic [N_CH-1:0][W_STG-1:0] stg_q, stg_d;

    logic                       res_vld_q, res_vld_d;
    logic                       res_q, res_d;
    logic [W_CH-1:0]            res_ch_q, res_ch_d;
    logic [W_STG-1:0]           res_stg_q, res_stg_d;

    logic                         ch_ok, beat, reject, last, decide;
    logic [W_STG-1:0]             cur_stg;
    logic [W_STAGE_THRESHOLD-1:0] th_rd;
    logic signed [W_ACC-1:0]      cur_acc, leaf_x, thr_x, sum;

    // A new beat may enter whenever the output slot is empty or being drained.
    assign din_ready = !res_vld_q || result_ready;

    // Out-of-range channels are accepted but must not touch any state.
    assign ch_ok   = {1'b0, din_ch} < (W_CH+1)'(N_CH);
    assign beat    = din_valid && din_ready && ch_ok;
    assign cur_stg = ch_ok ? stg_q[din_ch] : '0;
    assign cur_acc = ch_ok ? $signed(acc_q[din_ch]) : '0;

    stage_threshold_rf #(
        .STAGE_NUM         (STAGE_NUM),
        .W_STAGE_THRESHOLD (W_STAGE_THRESHOLD),
        .W_STG             (W_STG)
    ) u_th_rf (
        .clk       (clk),
        .wr_en_i   (cfg_we),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_data),
        .rd_addr_i (cur_stg),
        .rd_data_o (th_rd)
    );

    assign leaf_x = {{(W_ACC-W_LEAF){din_data[W_LEAF-1]}}, din_data};
    assign thr_x  = {{(W_ACC-W_STAGE_THRESHOLD){th_rd[W_STAGE_THRESHOLD-1]}}, th_rd};
    assign sum    = cur_acc + leaf_x;
    assign reject = sum < thr_x;
    assign last   = cur_stg == W_STG'(STAGE_NUM-1);
    assign decide = beat && din_eot && (reject || last);

    // Per-channel accumulator and stage pointer update.
    always_comb begin
        acc_d = acc_q;
        stg_d = stg_q;
        if (beat) begin
            if (!din_eot) begin
                acc_d[din_ch] = sum;
            end else begin
                acc_d[din_ch] = '0;
                // Decision taken (reject or final accept) restarts the window at stage 0.
                stg_d[din_ch] = (reject || last) ? '0 : cur_stg + 1'b1;
            end
        end
    end

    // One-entry output register; holds its contents until drained.
    always_comb begin
        res_vld_d = res_vld_q && !result_ready;
        res_d     = res_q;
        res_ch_d  = res_ch_q;
        res_stg_d = res_stg_q;
        if (decide) begin
            res_vld_d = 1'b1;
            res_d     = !reject;
            res_ch_d  = din_ch;
            res_stg_d = cur_stg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            stg_q     <= '0;
            res_vld_q <= 1'b0;
            res_q     <= 1'b0;
            res_ch_q  <= '0;
            res_stg_q <= '0;
        end else begin
            acc_q     <= acc_d;
            stg_q     <= stg_d;
            res_vld_q <= res_vld_d;
            res_q     <= res_d;
            res_ch_q  <= res_ch_d;
            res_stg_q <= res_stg_d;
        end
    end

    assign result_valid = res_vld_q;
    assign result       = res_q;
    assign result_ch    = res_ch_q;

`ifdef STAGE_ACCUM_MC_DEPTH_OUT_EN
    assign result_stage = res_stg_q;
`else
    // Stage is tracked regardless so both builds share one datapath.
    logic unused_stg;
    assign unused_stg = ^res_stg_q;
`endif

endmodule

// File: tb/tb_stage_accum_mc.sv
// Bench for stage_accum_mc: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a behavioural model.
module tb_stage_accum_mc;

    localparam int NCH = 4;
    localparam int NST = 25;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic signed [12:0] din_data = '0;
    logic [1:0]        din_ch = '0;
    logic              din_eot = 1'b0;
    logic              cfg_we = 1'b0;
    logic [4:0]        cfg_addr = '0;
    logic signed [10:0] cfg_data = '0;
    logic              result_valid;
    logic              result_ready = 1'b1;
    logic              result;
    logic [1:0]        result_ch;
`ifdef STAGE_ACCUM_MC_DEPTH_OUT_EN
    logic [4:0]        result_stage;
`endif

    stage_accum_mc dut (
        .clk(clk), .rst(rst),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .din_ch(din_ch), .din_eot(din_eot),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .result(result),
`ifdef STAGE_ACCUM_MC_DEPTH_OUT_EN
        .result_stage(result_stage),
`endif
        .result_ch(result_ch)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    int m_acc [NCH];
    int m_stg [NCH];
    int m_th  [NST];
    bit m_v;
    int m_r, m_ch, m_s;

    always @(posedge clk) begin
        bit rdy;
        int c, s;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin m_acc[i] = 0; m_stg[i] = 0; end
            m_v = 0; m_r = 0; m_ch = 0; m_s = 0;
        end else begin
            rdy = !m_v || result_ready;
            if (m_v && result_ready) m_v = 0;
            if (din_valid && rdy) begin
                c = int'(din_ch);
                s = m_acc[c] + int'(din_data);
                if (!din_eot) m_acc[c] = s;
                else begin
                    m_acc[c] = 0;
                    if (s < m_th[m_stg[c]]) begin
                        m_v = 1; m_r = 0; m_ch = c; m_s = m_stg[c]; m_stg[c] = 0;
                    end else if (m_stg[c] == NST-1) begin
                        m_v = 1; m_r = 1; m_ch = c; m_s = NST-1; m_stg[c] = 0;
                    end else m_stg[c]++;
                end
            end
        end
        // Write lands after the compare above, so a same-cycle compare sees the old value.
        if (cfg_we && int'(cfg_addr) < NST) m_th[cfg_addr] = int'(cfg_data);
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model din_ready", int'(din_ready), int'(!m_v || result_ready));
            chk("model result_valid", int'(result_valid), int'(m_v));
            if (m_v) begin
                chk("model result", int'(result), m_r);
                chk("model result_ch", int'(result_ch), m_ch);
`ifdef STAGE_ACCUM_MC_DEPTH_OUT_EN
                chk("model result_stage", int'(result_stage), m_s);
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    task automatic cfg(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = 5'(a); cfg_data = 11'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_all(input int d);
        for (int i = 0; i < NST; i++) cfg(i, d);
    endtask

    task automatic beat(input int c, input int d, input bit e);
        din_valid = 1'b1; din_ch = 2'(c); din_data = 13'(d); din_eot = e;
        tick();
        din_valid = 1'b0; din_eot = 1'b0;
    endtask

    initial begin
        do_reset();
        settle();
        chk("reset result_valid", int'(result_valid), 0);
        chk("reset result", int'(result), 0);
        chk("reset result_ch", int'(result_ch), 0);
        chk("reset din_ready", int'(din_ready), 1);

        // 1: continue then reject at stage 1
        cfg(0, 5); cfg(1, 0);
        beat(0, 3, 0);
        beat(0, 4, 1);
        settle();
        chk("t1 continue no result", int'(result_valid), 0);
        beat(0, -20, 1);
        settle();
        chk("t1 reject valid", int'(result_valid), 1);
        chk("t1 reject result", int'(result), 0);
        chk("t1 reject ch", int'(result_ch), 0);
`ifdef STAGE_ACCUM_MC_DEPTH_OUT_EN
        chk("t1 reject stage", int'(result_stage), 1);
`endif

        // 2: all channels pass 25 stages, interleaved
        do_reset();
        cfg_all(-1024);
        for (int s = 0; s < NST; s++)
            for (int c = 0; c < NCH; c++) begin
                beat(c, int'($urandom_range(0, 2000)) - 1000, 1);
                if (s == NST-1) begin
                    settle();
                    chk("t2 accept valid", int'(result_valid), 1);
                    chk("t2 accept result", int'(result), 1);
                    chk("t2 accept ch", int'(result_ch), c);
`ifdef STAGE_ACCUM_MC_DEPTH_OUT_EN
                    chk("t2 accept stage", int'(result_stage), NST-1);
`endif
                end
            end
        // stage pointers back at 0: a single reject beat decides at stage 0
        cfg(0, 1000);
        beat(3, 0, 1);
        settle();
        chk("t2 stg reset ch3", int'(result_valid), 1);
        chk("t2 stg reset result", int'(result), 0);

        // 3: backpressure hold
        do_reset();
        cfg(0, 1000);
        result_ready = 1'b0;
        beat(1, 0, 1);
        din_valid = 1'b1; din_ch = 2'd2; din_data = 13'sd5; din_eot = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("t3 hold din_ready", int'(din_ready), 0);
            chk("t3 hold valid", int'(result_valid), 1);
            chk("t3 hold result", int'(result), 0);
            chk("t3 hold ch", int'(result_ch), 1);
            tick();
        end
        result_ready = 1'b1;
        settle();
        chk("t3 release din_ready", int'(din_ready), 1);
        tick();
        din_valid = 1'b0;
        settle();
        chk("t3 drained", int'(result_valid), 0);

        // 4a: sum equal to threshold continues through every stage and accepts
        do_reset();
        cfg_all(7);
        for (int s = 0; s < NST; s++) begin
            beat(3, 7, 1);
            settle();
            chk("t4 equal valid", int'(result_valid), (s == NST-1) ? 1 : 0);
        end
        chk("t4 equal accept", int'(result), 1);
        chk("t4 equal ch", int'(result_ch), 3);
        // 4b: largest negative sum does not overflow
        do_reset();
        cfg(0, 0);
        for (int i = 0; i < 211; i++) beat(0, -4096, (i == 210));
        settle();
        chk("t4 max neg valid", int'(result_valid), 1);
        chk("t4 max neg result", int'(result), 0);

        // 5: same-cycle threshold write uses old value
        do_reset();
        cfg(0, 0);
        beat(0, 25, 0);
        din_valid = 1'b1; din_ch = 2'd0; din_data = 13'sd25; din_eot = 1'b1;
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 11'sd100;
        tick();
        din_valid = 1'b0; din_eot = 1'b0; cfg_we = 1'b0;
        settle();
        chk("t5 old thr continue", int'(result_valid), 0);
        do_reset();
        beat(0, 25, 0);
        beat(0, 25, 1);
        settle();
        chk("t5 new thr valid", int'(result_valid), 1);
        chk("t5 new thr reject", int'(result), 0);
        // ignored out-of-range write
        cfg(27, -1000);

        // 6: reset mid-stage clears partial sum
        do_reset();
        cfg(0, 2);
        beat(2, 30, 0);
        beat(2, 7, 0);
        do_reset();
        beat(2, 1, 1);
        settle();
        chk("t6 valid", int'(result_valid), 1);
        chk("t6 reject", int'(result), 0);
        chk("t6 ch", int'(result_ch), 2);
`ifdef STAGE_ACCUM_MC_DEPTH_OUT_EN
        chk("t6 stage", int'(result_stage), 0);
`endif

        // Randomized phase against the model
        do_reset();
        for (int i = 0; i < NST; i++) cfg(i, int'($urandom_range(0, 600)) - 300);
        for (int n = 0; n < 4000; n++) begin
            din_valid    = ($urandom_range(0, 3) != 0);
            din_ch       = 2'($urandom_range(0, NCH-1));
            din_data     = 13'(int'($urandom_range(0, 400)) - 200);
            din_eot      = ($urandom_range(0, 3) == 0);
            result_ready = ($urandom_range(0, 2) != 0);
            cfg_we       = ($urandom_range(0, 15) == 0);
            cfg_addr     = 5'($urandom_range(0, 31));
            cfg_data     = 11'(int'($urandom_range(0, 600)) - 300);
            rst          = ($urandom_range(0, 499) == 0);
            tick();
        end
        din_valid = 1'b0; cfg_we = 1'b0; rst = 1'b0; result_ready = 1'b1;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
